// File: rtl/ks_pkg.sv
// Shared definitions for the pipelined Kogge-Stone adder: op encoding and
// pipeline depth helpers.
package ks_pkg;

    typedef enum logic {
        KS_ADD = 1'b0,
        KS_SUB = 1'b1
    } ks_op_e;

    function automatic int ks_levels(input int n);
        return $clog2(n);
    endfunction

    // One register after every reg_every prefix levels, the last one being the output register.
    function automatic int ks_lat(input int n, input int reg_every);
        return (ks_levels(n) + reg_every - 1) / reg_every;
    endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// One Kogge-Stone prefix level: black cells at distance SPAN, plain
// pass-through for the low SPAN bits.
module ks_prefix_level #(
    parameter int N    = 16,
    parameter int SPAN = 1
) (
    input  logic [N-1:0] g_i,
    input  logic [N-1:0] p_i,
    output logic [N-1:0] g_o,
    output logic [N-1:0] p_o
);

    for (genvar i = 0; i < N; i++) begin : g_cell
        if (i >= SPAN) begin : g_black
            assign g_o[i] = g_i[i] | (p_i[i] & g_i[i-SPAN]);
            assign p_o[i] = p_i[i] & p_i[i-SPAN];
        end else begin : g_pass
            assign g_o[i] = g_i[i];
            assign p_o[i] = p_i[i];
        end
    end

endmodule

// File: rtl/pipelined_ks_adder.sv
// Pipelined Kogge-Stone add/subtract with valid/ready flow control and a
// sideband tag that travels with each operation.
module pipelined_ks_adder
    import ks_pkg::*;
#(
    parameter int N         = 16,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     dataa,
    input  logic [N-1:0]     datab,
    input  logic             cin,
    input  logic             op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LEVELS = ks_levels(N);
    localparam int LAT    = ks_lat(N, REG_EVERY);

    // ---------------- flow control ----------------
    logic [LAT:1] vld_q, vld_d;
    logic [LAT:1] adv;
    logic [LAT:0] vin;

    assign vin = {vld_q, in_valid};

    // A stage advances unless it and every stage downstream of it is full while out_ready is low.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        adv      = '0;
        vld_d    = vld_q;
        for (int s = LAT; s >= 1; s--) begin
            all_full = all_full & vld_q[s];
            adv[s]   = out_ready | ~all_full;
            if (adv[s]) vld_d[s] = vin[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_q <= '0;
        else        vld_q <= vld_d;
    end

    assign in_ready  = adv[1];
    assign out_valid = vld_q[LAT];

    // ---------------- level 0 ----------------
    logic [N-1:0]     b_eff;
    logic             c0;
    logic [N-1:0]     g_b  [LEVELS];
    logic [N-1:0]     p_b  [LEVELS];
    logic [N-1:0]     p0_b [LEVELS];
    logic             am_b [LEVELS];
    logic             bm_b [LEVELS];
    logic             c0_b [LEVELS];
    logic [TAG_W-1:0] tag_b[LEVELS];
    logic [N-1:0]     g_a  [1:LEVELS];
    logic [N-1:0]     p_a  [1:LEVELS];

    assign b_eff = (op == KS_SUB) ? ~datab : datab;
    assign c0    = (op == KS_SUB) ? 1'b1 : cin;

    // Carry-in enters as a generate at bit -1, folded into bit 0.
    assign p_b[0]   = dataa ^ b_eff;
    assign g_b[0]   = (dataa & b_eff) | {{(N-1){1'b0}}, p_b[0][0] & c0};
    assign p0_b[0]  = p_b[0];
    assign am_b[0]  = dataa[N-1];
    assign bm_b[0]  = b_eff[N-1];
    assign c0_b[0]  = c0;
    assign tag_b[0] = in_tag;

    // ---------------- prefix levels with optional stage registers ----------------
    for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
        ks_prefix_level #(.N(N), .SPAN(1 << (k-1))) u_lvl (
            .g_i (g_b[k-1]),
            .p_i (p_b[k-1]),
            .g_o (g_a[k]),
            .p_o (p_a[k])
        );

        if (k < LEVELS) begin : g_bnd
            if (k % REG_EVERY == 0) begin : g_reg
                localparam int S = k / REG_EVERY;
                logic             en;
                logic [N-1:0]     g_q, p_q, p0_q;
                logic             am_q, bm_q, c0_q;
                logic [TAG_W-1:0] tag_q;

                assign en = adv[S] & vin[S-1];

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        g_q   <= '0;
                        p_q   <= '0;
                        p0_q  <= '0;
                        am_q  <= 1'b0;
                        bm_q  <= 1'b0;
                        c0_q  <= 1'b0;
                        tag_q <= '0;
                    end else if (en) begin
                        g_q   <= g_a[k];
                        p_q   <= p_a[k];
                        p0_q  <= p0_b[k-1];
                        am_q  <= am_b[k-1];
                        bm_q  <= bm_b[k-1];
                        c0_q  <= c0_b[k-1];
                        tag_q <= tag_b[k-1];
                    end
                end

                assign g_b[k]   = g_q;
                assign p_b[k]   = p_q;
                assign p0_b[k]  = p0_q;
                assign am_b[k]  = am_q;
                assign bm_b[k]  = bm_q;
                assign c0_b[k]  = c0_q;
                assign tag_b[k] = tag_q;
            end else begin : g_wire
                assign g_b[k]   = g_a[k];
                assign p_b[k]   = p_a[k];
                assign p0_b[k]  = p0_b[k-1];
                assign am_b[k]  = am_b[k-1];
                assign bm_b[k]  = bm_b[k-1];
                assign c0_b[k]  = c0_b[k-1];
                assign tag_b[k] = tag_b[k-1];
            end
        end
    end

    // ---------------- result and output register ----------------
    logic [N-1:0]     gf;
    logic [N-1:0]     sum_d, sum_q;
    logic             cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q;
    logic [TAG_W-1:0] tag_q;
    logic             out_en;
    logic             unused_bits;

    assign gf     = g_a[LEVELS];
    assign sum_d  = p0_b[LEVELS-1] ^ {gf[N-2:0], c0_b[LEVELS-1]};
    assign cout_d = gf[N-1];
    assign ovf_d  = (am_b[LEVELS-1] == bm_b[LEVELS-1]) && (sum_d[N-1] != am_b[LEVELS-1]);
    assign zero_d = ~|sum_d;
    assign out_en = adv[LAT] & vin[LAT-1];

    // Final group-propagate and the top valid tap have no consumer.
    assign unused_bits = ^{p_a[LEVELS], vin[LAT]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            tag_q  <= '0;
        end else if (out_en) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            tag_q  <= tag_b[LEVELS-1];
        end
    end

    assign sum     = sum_q;
    assign cout    = cout_q;
    assign ovf     = ovf_q;
    assign zero    = zero_q;
    assign out_tag = tag_q;

endmodule
